rchan_receiver: RTL and testbench

//  Clocked responder for the right-hand 4-phase bundled-data channel (Rreq/Rack) driven by the

---
 rtl/rchan_pkg.sv | 22 ++
 rtl/rchan_receiver_if.sv | 23 ++
 rtl/rchan_fifo.sv | 52 +++++
 rtl/rchan_receiver.sv | 106 ++++++++++
 tb/tb_rchan_receiver.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rchan_pkg.sv
// Shared types and helpers for the right-hand channel receiver.
// FIFO entries are packed as {err, data}, so an entry is W+1 bits wide.
package rchan_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} rchan_state_t;

   localparam int RCHAN_W_DEF     = 8;
   localparam int RCHAN_DEPTH_DEF = 4;
   localparam int RCHAN_ENTRY_W   = RCHAN_W_DEF + 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int entry_w(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/rchan_receiver_if.sv
// Channel bundle: 4-phase Rreq/Rack with bundled data and error rails,
// plus the synchronous valid/ready output stream.
interface rchan_receiver_if #(parameter int W = 8);
   logic         Rreq;
   logic [W-1:0] Rdata;
   logic         Err1;
   logic         Err0;
   logic         Rack;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_err;
   logic         out_ready;

   modport slave (
      input  Rreq, Rdata, Err1, Err0, out_ready,
      output Rack, out_valid, out_data, out_err
   );

   modport master (
      output Rreq, Rdata, Err1, Err0, out_ready,
      input  Rack, out_valid, out_data, out_err
   );
endinterface

// File: rtl/rchan_fifo.sv
// DEPTH-entry FIFO with wrap-bit pointers. Exposes the head as it will be
// after this cycle's pop, so the top can register the output stage.
module rchan_fifo
   import rchan_pkg::*;
#(
   parameter int EW    = RCHAN_ENTRY_W,
   parameter int DEPTH = RCHAN_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] din,
   output logic          full,
   output logic          empty,
   output logic [EW-1:0] head_nxt,
   output logic          avail_nxt
);
   localparam int AW = clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, cnt;
   logic          do_push, do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign cnt     = wr_ptr - rd_ptr;

   // Availability ignores this cycle's push: a new entry reaches the output
   // one cycle after it is written, and the head read never races its write.
   assign rd_ptr_nxt = rd_ptr + PW'(do_pop);
   assign head_nxt   = mem[rd_ptr_nxt[AW-1:0]];
   assign avail_nxt  = (cnt != PW'(do_pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/rchan_receiver.sv
// Clocked 4-phase responder: synchronises Rreq, captures {err,data} into a FIFO,
// and presents it as a registered valid/ready stream. Option: RCHAN_SYNC2_EN.
module rchan_receiver
   import rchan_pkg::*;
#(
   parameter int W     = RCHAN_W_DEF,
   parameter int DEPTH = RCHAN_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   rchan_receiver_if.slave    rif
);
   localparam int EW = entry_w(W);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_ACK  = ACK;

`ifdef RCHAN_SYNC2_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 1;
`endif

   logic [SYNC-1:0] req_pipe;
   logic            req_s;
   logic [0:0]      state;
   logic            rack_q;
   logic            push, pop, full, empty, avail_nxt;
   logic [EW-1:0]   din, head_nxt;
   logic            err_cap;
   logic            vld_q;
   logic [W-1:0]    data_q;
   logic            err_q;

`ifdef RCHAN_SYNC2_EN
   always_ff @(posedge clk) begin
      if (rst) req_pipe <= '0;
      else     req_pipe <= {req_pipe[0], rif.Rreq};
   end
`else
   always_ff @(posedge clk) begin
      if (rst) req_pipe <= '0;
      else     req_pipe <= rif.Rreq;
   end
`endif

   assign req_s = req_pipe[SYNC-1];

   // Both rails high is illegal and is recorded as an error, same as Err1 alone.
   assign err_cap = rif.Err1 | (rif.Err1 & rif.Err0);
   assign din     = {err_cap, rif.Rdata};
   assign push    = (state == S_IDLE) && req_s && !full;
   assign pop     = vld_q & rif.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         rack_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (push) begin
               rack_q <= 1'b1;
               state  <= S_ACK;
            end
            S_ACK: if (!req_s) begin
               rack_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               rack_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   rchan_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .full      (full),
      .empty     (empty),
      .head_nxt  (head_nxt),
      .avail_nxt (avail_nxt)
   );

   // Registered head: holds its value while stalled since the slot cannot be
   // overwritten until it is popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         vld_q <= avail_nxt;
         if (avail_nxt) {err_q, data_q} <= head_nxt;
      end
   end

   assign rif.Rack      = rack_q;
   assign rif.out_valid = vld_q & ~empty;
   assign rif.out_data  = data_q;
   assign rif.out_err   = err_q;

endmodule

// File: tb/tb_rchan_receiver.sv
// Directed bench for rchan_receiver; latencies follow RCHAN_SYNC2_EN like the RTL.
module tb_rchan_receiver;
   localparam int W     = 8;
   localparam int DEPTH = 4;
`ifdef RCHAN_SYNC2_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rchan_receiver_if #(.W(W)) rif ();
   rchan_receiver #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .rif(rif));

   int checks   = 0;
   int failures = 0;
   logic [W:0] got_q [$];
   logic mon_en = 1'b0;
   logic done6  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_rack(input logic exp, input string tag);
      int n = 0;
      while (rif.Rack !== exp && n < 200) begin
         step();
         n++;
      end
      chk(tag, rif.Rack, exp);
   endtask

   task automatic send_tok(input logic [W-1:0] d, input logic e1, input logic e0);
      rif.Rdata = d;
      rif.Err1  = e1;
      rif.Err0  = e0;
      rif.Rreq  = 1'b1;
      wait_rack(1'b1, "send_ack_hi");
      rif.Rreq  = 1'b0;
      wait_rack(1'b0, "send_ack_lo");
   endtask

   always @(negedge clk)
      if (mon_en && rif.out_valid && rif.out_ready)
         got_q.push_back({rif.out_err, rif.out_data});

   initial begin
      rif.Rreq = 0; rif.Rdata = '0; rif.Err1 = 0; rif.Err0 = 0; rif.out_ready = 0;
      step(2);
      rst = 1'b0;
      chk("rst_rack",  rif.Rack, 0);
      chk("rst_valid", rif.out_valid, 0);
      chk("rst_data",  rif.out_data, 0);
      chk("rst_err",   rif.out_err, 0);

      // 1: single token latency
      rif.Rdata = 8'hA5; rif.Err0 = 1; rif.Err1 = 0; rif.Rreq = 1;
      step(SYNC);
      chk("t1_rack_early", rif.Rack, 0);
      step();
      chk("t1_rack_hi", rif.Rack, 1);
      chk("t1_valid_early", rif.out_valid, 0);
      step();
      chk("t1_valid", rif.out_valid, 1);
      chk("t1_data", rif.out_data, 8'hA5);
      chk("t1_err", rif.out_err, 0);
      rif.Rreq = 0;
      step(SYNC);
      chk("t1_rack_hold", rif.Rack, 1);
      step();
      chk("t1_rack_lo", rif.Rack, 0);
      rif.out_ready = 1; step(); rif.out_ready = 0;
      chk("t1_popped", rif.out_valid, 0);

      // 2: fill, blocked 5th token, pop, drain
      for (int i = 1; i <= 4; i++) send_tok(W'(i), 0, 1);
      rif.Rdata = 8'h05; rif.Rreq = 1;
      step(6);
      chk("t2_full_block", rif.Rack, 0);
      chk("t2_head", rif.out_data, 8'h01);
      rif.out_ready = 1; step(); rif.out_ready = 0;
      chk("t2_no_same_cycle", rif.Rack, 0);
      step();
      chk("t2_push_after", rif.Rack, 1);
      rif.Rreq = 0;
      wait_rack(1'b0, "t2_ack_lo");
      for (int i = 2; i <= 5; i++) begin
         chk("t2_drain_valid", rif.out_valid, 1);
         chk("t2_drain_data", rif.out_data, i);
         rif.out_ready = 1; step(); rif.out_ready = 0;
      end
      chk("t2_empty", rif.out_valid, 0);

      // 3: streaming
      got_q.delete(); mon_en = 1; rif.out_ready = 1;
      for (int i = 0; i < 10; i++) send_tok(W'(i), 0, 1);
      step(5);
      chk("t3_count", got_q.size(), 10);
      for (int i = 0; i < 10; i++) chk("t3_order", got_q[i], i);

      // 4: error rails
      got_q.delete();
      send_tok(8'h11, 1, 0);
      send_tok(8'h22, 1, 1);
      send_tok(8'h33, 0, 0);
      send_tok(8'h44, 0, 1);
      step(5);
      chk("t4_count", got_q.size(), 4);
      chk("t4_e10", got_q[0], {1'b1, 8'h11});
      chk("t4_e11", got_q[1], {1'b1, 8'h22});
      chk("t4_e00", got_q[2], {1'b0, 8'h33});
      chk("t4_e01", got_q[3], {1'b0, 8'h44});
      mon_en = 0;

      // 5: reset mid-ACK with Rreq held high
      rif.out_ready = 0;
      rif.Rdata = 8'h5A; rif.Err1 = 0; rif.Err0 = 1; rif.Rreq = 1;
      wait_rack(1'b1, "t5_pre_ack");
      rst = 1; step(); rst = 0;
      chk("t5_rack_rst", rif.Rack, 0);
      chk("t5_valid_rst", rif.out_valid, 0);
      step(SYNC);
      chk("t5_rack_wait", rif.Rack, 0);
      step();
      chk("t5_recapture", rif.Rack, 1);
      step();
      chk("t5_valid", rif.out_valid, 1);
      chk("t5_data", rif.out_data, 8'h5A);
      rif.Rreq = 0;
      wait_rack(1'b0, "t5_ack_lo");
      rif.out_ready = 1; step(); rif.out_ready = 0;
      chk("t5_empty", rif.out_valid, 0);

      // 6: wrap with random back-pressure
      got_q.delete(); mon_en = 1;
      fork
         begin
            for (int i = 0; i < 3 * DEPTH; i++) send_tok(W'(8'h80 + i), 0, 1);
            done6 = 1;
         end
         begin
            while (!done6) begin
               rif.out_ready = 1'($urandom_range(0, 1));
               step();
            end
         end
      join
      rif.out_ready = 1;
      step(12);
      chk("t6_count", got_q.size(), 3 * DEPTH);
      for (int i = 0; i < 3 * DEPTH; i++) chk("t6_order", got_q[i], 8'h80 + i);
      chk("t6_empty", rif.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL tb_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
